// File: rtl/gate_checker.sv
// Sweeps all four {a,b} vectors into a 2-input gate and checks c against TRUTH.
// Define GATE_CHECKER_FAILMASK_EN to implement the per-vector fail_mask register.
module gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       mismatch;
  logic       sample;
  logic       launch;

  assign mismatch = (c != TRUTH[vec_q]);
  assign sample   = (state_q == SETTLE) && (cnt_q == '0);
  assign launch   = (state_q != SETTLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (sample && vec_q == 2'd3) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    vec_d  = vec_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    if (launch) begin
      cnt_d  = RELOAD;
      vec_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      err_d  = '0;
    end else if (state_q == SETTLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        err_d = err_q + 3'(mismatch);
        if (vec_q != 2'd3) begin
          vec_d = vec_q + 2'd1;
          cnt_d = RELOAD;
        end else begin
          // pass must see the final vector's result, so it uses err_d, not err_q
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end
      end
    end
  end

`ifdef GATE_CHECKER_FAILMASK_EN
  logic [3:0] mask_q, mask_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end

  always_comb begin
    mask_d = mask_q;
    if (launch)
      mask_d = '0;
    else if (sample && mismatch)
      mask_d[vec_q] = 1'b1;
  end

  assign fail_mask = mask_q;
`else
  assign fail_mask = '0;
`endif

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: behavioural gate models drive c, expectations come from truth-table arithmetic.
module tb_gate_checker;

  localparam int unsigned S     = 4;
  localparam logic [3:0]  NAND  = 4'b0111;
  localparam logic [3:0]  AND_T = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [3:0] gate_tt = NAND;

  logic       start1 = 1'b0;
  logic       a1, b1, c1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign c  = gate_tt[{a, b}];
  assign c1 = ~(a1 & b1);

  gate_checker #(.SETTLE_CYCLES(S), .TRUTH(NAND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_checker #(.SETTLE_CYCLES(1), .TRUTH(NAND)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  function automatic logic [3:0] exp_mask(input logic [3:0] g);
`ifdef GATE_CHECKER_FAILMASK_EN
    return g ^ NAND;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a, b, busy, done, pass, err_count, fail_mask} !== 12'd0) begin
      failures++;
      $display("FAIL reset_state: got %b required 0", {a, b, busy, done, pass, err_count, fail_mask});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // One full sweep with gate table g; optionally pulses start at cycle pulse_at.
  task automatic run_sweep(input logic [3:0] g, input int pulse_at, input string name);
    int unsigned e_err;
    logic [3:0]  e_mask;
    logic [1:0]  e_ab;
    gate_tt = g;
    e_err   = $countones(g ^ NAND);
    e_mask  = exp_mask(g);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= 4 * S; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (k < 4 * S) begin
        e_ab = 2'(k / S);
        if ({a, b, busy, done} !== {e_ab, 2'b10}) begin
          failures++;
          $display("FAIL %s_cycle%0d: ab/busy/done=%b required %b", name, k, {a, b, busy, done}, {e_ab, 2'b10});
        end
      end else begin
        if ({a, b, busy, done, pass, err_count, fail_mask} !==
            {2'b11, 2'b01, (e_err == 0), 3'(e_err), e_mask}) begin
          failures++;
          $display("FAIL %s_result: ab,busy,done,pass,err,mask=%b,%b,%b,%b,%0d,%b required 11,0,1,%b,%0d,%b",
                   name, {a, b}, busy, done, pass, err_count, fail_mask, (e_err == 0), e_err, e_mask);
        end
      end
      start = (k == pulse_at);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({a, b, done, busy, pass, err_count} !== {2'b11, 2'b10, (e_err == 0), 3'(e_err)}) begin
      failures++;
      $display("FAIL %s_hold: ab,done,busy,pass,err=%b,%b,%b,%b,%0d", name, {a, b}, done, busy, pass, err_count);
    end
  endtask

  task automatic test_good_nand();
    run_sweep(NAND, -1, "nand");
  endtask

  task automatic test_faulty_gates();
    run_sweep(AND_T, -1, "and");
    run_sweep(4'b1111, -1, "stuck1");
  endtask

  task automatic test_random_gates();
    for (int i = 0; i < 6; i++)
      run_sweep(4'($urandom_range(0, 15)), -1, "rand");
  endtask

  task automatic test_start_while_busy();
    run_sweep(4'b0110, 6, "restart_ignored");
  endtask

  task automatic test_reset_mid_sweep();
    gate_tt = NAND;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, busy, done, pass, err_count, fail_mask} !== 12'd0) begin
      failures++;
      $display("FAIL async_reset: got %b required 0", {a, b, busy, done, pass, err_count, fail_mask});
    end
    @(negedge clk) rst_n = 1'b1;
    run_sweep(NAND, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy1, done1, pass1} !== ((k % 5 == 4) ? 3'b011 : 3'b100)) begin
        failures++;
        $display("FAIL b2b_cycle%0d: busy,done,pass=%b required %b", k, {busy1, done1, pass1},
                 ((k % 5 == 4) ? 3'b011 : 3'b100));
      end
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_nand();
    test_faulty_gates();
    test_random_gates();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
